// File: rtl/intfdmux6.sv
// intfdmux6: marker-locked demultiplexer that rebuilds MUX-lane words from the 38 MHz line
module intfdmux6 #(
   parameter int LINEBIT = 12,
   parameter int MUX     = 6,
   parameter int FRAME   = 8,
   parameter int LOCKCNT = 3,
   parameter int LOSCNT  = 4,
   parameter int DATABIT = LINEBIT*MUX
) (
   input  logic               iclk38,
   input  logic               rst_,
   input  logic [LINEBIT-1:0] idat,
   input  logic               isyn,
   output logic [DATABIT-1:0] odat,
   output logic               ovld,
   output logic               olock,
   output logic               oerr
);
   typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;
   localparam logic [3:0] FLAST = 4'(FRAME-1);
   localparam logic [3:0] LLAST = 4'(MUX-1);
   localparam logic [3:0] LDONE = 4'(MUX);
   localparam int AW = DATABIT-LINEBIT;
   state_t st, st_n;
   logic arm;
   logic [3:0] fcnt, fcnt_n, pos, pos_n, widx;
   logic [2:0] good, good_n, miss, miss_n;
   logic mflag, mflag_n;
   logic [AW-1:0] asm_q, asm_n;
   logic fs, ontime, early, missing, err, fmiss, emit;

   // frame timing, lock FSM and lane assembly; lane MUX-1 bypasses storage straight into odat
   always_comb begin
      ontime = isyn && fcnt == FLAST;
      early = isyn && fcnt < FLAST;
      missing = !isyn && fcnt == FLAST;
      fs = (st == SYNC) ? fcnt == FLAST : isyn;
      fcnt_n = fs ? 4'd0 : (st != SYNC && fcnt == FLAST) ? fcnt : fcnt + 4'd1;
      widx = fs ? 4'd0 : pos;
      pos_n = (widx == LDONE) ? widx : widx + 4'd1;
      asm_n = asm_q;
      for (int i = 0; i < MUX-1; i++)
         if (widx == 4'(i)) asm_n[AW-1-i*LINEBIT -: LINEBIT] = idat;
      emit = st == SYNC && widx == LLAST;
      st_n = st;
      good_n = good;
      miss_n = miss;
      mflag_n = 1'b0;
      err = 1'b0;
      fmiss = 1'b0;
      case (st)
         HUNT: begin
            if (isyn) begin
               st_n = PRESYNC;
               good_n = 3'd0;
            end
         end
         PRESYNC: begin
            if (ontime) begin
               good_n = good + 3'd1;
               if (good_n == 3'(LOCKCNT)) begin
                  st_n = SYNC;
                  miss_n = 3'd0;
               end
            end else if (early) begin
               err = 1'b1;
               good_n = 3'd0;
            end else if (missing) begin
               err = 1'b1;
               st_n = HUNT;
            end
         end
         SYNC: begin
            err = early || missing;
            fmiss = err && !mflag;
            mflag_n = fs ? 1'b0 : mflag || early;
            if (ontime) miss_n = 3'd0;
            else if (fmiss) begin
               miss_n = miss + 3'd1;
               if (miss_n == 3'(LOSCNT)) st_n = HUNT;
            end
         end
         default: st_n = HUNT;
      endcase
   end

   // registers; the first edge after reset release is still treated as reset
   always_ff @(posedge iclk38 or negedge rst_) begin
      if (!rst_) begin
         arm <= 1'b0;
         st <= HUNT;
         fcnt <= FLAST;
         pos <= '0;
         good <= '0;
         miss <= '0;
         mflag <= 1'b0;
         asm_q <= '0;
         odat <= '0;
         ovld <= 1'b0;
         olock <= 1'b0;
         oerr <= 1'b0;
      end else if (!arm) begin
         arm <= 1'b1;
      end else begin
         st <= st_n;
         fcnt <= fcnt_n;
         pos <= pos_n;
         good <= good_n;
         miss <= miss_n;
         mflag <= mflag_n;
         asm_q <= asm_n;
         if (emit) odat <= {asm_q, idat};
         ovld <= emit;
         olock <= st_n == SYNC;
         oerr <= err;
      end
   end
endmodule

// File: tb/tb_intfdmux6.sv
// tb_intfdmux6: directed stimulus with queued expected words checked by a separate monitor
module tb_intfdmux6;
   logic clk = 1'b0;
   logic rst_ = 1'b0;
   logic [11:0] idat1 = '0, idat2 = '0;
   logic isyn1 = 1'b0, isyn2 = 1'b0;
   logic [71:0] odat1, last1 = '0, e1;
   logic [47:0] odat2, e2;
   logic ovld1, olock1, oerr1, ovld2, olock2, oerr2;
   logic [71:0] q1[$];
   logic [47:0] q2[$];
   int ncmp = 0, nfail = 0, nerr1 = 0, nerr2 = 0, cyc = 0, last2 = -1;

   always #5 clk = ~clk;

   intfdmux6 u1 (.iclk38(clk), .rst_(rst_), .idat(idat1), .isyn(isyn1), .odat(odat1), .ovld(ovld1), .olock(olock1), .oerr(oerr1));
   intfdmux6 #(.MUX(4), .FRAME(4)) u2 (.iclk38(clk), .rst_(rst_), .idat(idat2), .isyn(isyn2), .odat(odat2), .ovld(ovld2), .olock(olock2), .oerr(oerr2));

   // monitor: pop expected words on every strobe, count error pulses, check back-to-back spacing
   always @(negedge clk) begin
      cyc++;
      if (oerr1) nerr1++;
      if (oerr2) nerr2++;
      if (ovld1) begin
         ncmp++;
         if (q1.size() == 0) begin
            nfail++;
            $display("FAIL dut1_unexpected_ovld: got strobe with odat %h, want no strobe", odat1);
         end else begin
            e1 = q1.pop_front();
            if (odat1 !== e1) begin
               nfail++;
               $display("FAIL dut1_odat: got %h want %h", odat1, e1);
            end
         end
      end
      if (ovld2) begin
         ncmp++;
         if (q2.size() == 0) begin
            nfail++;
            $display("FAIL dut2_unexpected_ovld: got strobe with odat %h, want no strobe", odat2);
         end else begin
            e2 = q2.pop_front();
            if (odat2 !== e2) begin
               nfail++;
               $display("FAIL dut2_odat: got %h want %h", odat2, e2);
            end
         end
         if (last2 >= 0) begin
            ncmp++;
            if (cyc - last2 != 4) begin
               nfail++;
               $display("FAIL dut2_period: got %0d clocks want 4", cyc - last2);
            end
         end
         last2 = cyc;
      end
   end

   task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
      ncmp++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      idat1 = '0;
      isyn1 = 1'b0;
      idat2 = '0;
      isyn2 = 1'b0;
      repeat (n) step();
   endtask

   task automatic f1(input logic [11:0] b, input bit m, input bit v, input int len);
      if (v) begin
         last1 = {b+12'd1, b+12'd2, b+12'd3, b+12'd4, b+12'd5, b+12'd6};
         q1.push_back(last1);
      end
      for (int k = 0; k < len; k++) begin
         idat1 = (k < 6) ? b + 12'(k+1) : 12'hFFF;
         isyn1 = m && k == 0;
         step();
      end
   endtask

   task automatic f2(input logic [11:0] b, input bit v);
      if (v) q2.push_back({b+12'd1, b+12'd2, b+12'd3, b+12'd4});
      for (int k = 0; k < 4; k++) begin
         idat2 = b + 12'(k+1);
         isyn2 = k == 0;
         step();
      end
   endtask

   initial begin
      idle(3);
      chk("reset_odat", odat1, 72'h0);
      chk("reset_ovld", 72'(ovld1), 72'h0);
      chk("reset_olock", 72'(olock1), 72'h0);
      chk("reset_oerr", 72'(oerr1), 72'h0);
      rst_ = 1'b1;
      idle(2);
      for (int n = 0; n < 3; n++) f1(12'h0A0, 1'b1, 1'b0, 8);
      chk("prelock_olock", 72'(olock1), 72'h0);
      f1(12'h0A0, 1'b1, 1'b1, 8);
      chk("lock_olock", 72'(olock1), 72'h1);
      chk("lock_first_word", odat1, 72'h0A1_0A2_0A3_0A4_0A5_0A6);
      for (int n = 0; n < 3; n++) f1(12'h100 + 12'(16*n), 1'b1, 1'b1, 8);
      chk("lock_no_oerr", 72'(nerr1), 72'd0);
      f1(12'h200, 1'b0, 1'b1, 8);
      f1(12'h210, 1'b1, 1'b1, 8);
      f1(12'h220, 1'b1, 1'b1, 8);
      chk("dropout_oerr_count", 72'(nerr1), 72'd1);
      chk("dropout_olock", 72'(olock1), 72'h1);
      for (int n = 0; n < 3; n++) f1(12'h300 + 12'(16*n), 1'b0, 1'b1, 8);
      chk("loss_olock_before_4th", 72'(olock1), 72'h1);
      f1(12'h330, 1'b0, 1'b0, 8);
      chk("loss_olock_after_4th", 72'(olock1), 72'h0);
      f1(12'h340, 1'b0, 1'b0, 8);
      chk("loss_oerr_count", 72'(nerr1), 72'd5);
      chk("loss_odat_hold", odat1, {12'h321, 12'h322, 12'h323, 12'h324, 12'h325, 12'h326});
      f1(12'h400, 1'b1, 1'b0, 6);
      f1(12'h410, 1'b1, 1'b0, 8);
      f1(12'h420, 1'b1, 1'b0, 8);
      f1(12'h430, 1'b1, 1'b0, 8);
      chk("early_oerr_count", 72'(nerr1), 72'd6);
      chk("early_olock_pending", 72'(olock1), 72'h0);
      f1(12'h440, 1'b1, 1'b1, 8);
      chk("early_olock_locked", 72'(olock1), 72'h1);
      f1(12'h450, 1'b1, 1'b1, 8);
      f1(12'h500, 1'b1, 1'b0, 3);
      rst_ = 1'b0;
      #1;
      chk("midreset_odat", odat1, 72'h0);
      chk("midreset_ovld", 72'(ovld1), 72'h0);
      chk("midreset_olock", 72'(olock1), 72'h0);
      chk("midreset_oerr", 72'(oerr1), 72'h0);
      idle(3);
      chk("midreset_held_olock", 72'(olock1), 72'h0);
      rst_ = 1'b1;
      f1(12'h600, 1'b1, 1'b0, 8);
      for (int n = 0; n < 3; n++) f1(12'h610 + 12'(16*n), 1'b1, 1'b0, 8);
      chk("relock_olock_pending", 72'(olock1), 72'h0);
      f1(12'h640, 1'b1, 1'b1, 8);
      chk("relock_olock", 72'(olock1), 72'h1);
      f1(12'h650, 1'b1, 1'b1, 8);
      chk("relock_oerr_count", 72'(nerr1), 72'd6);
      rst_ = 1'b0;
      idle(2);
      rst_ = 1'b1;
      idle(2);
      for (int n = 0; n < 3; n++) f2(12'h0A0, 1'b0);
      chk("b2b_prelock_olock", 72'(olock2), 72'h0);
      f2(12'h0A0, 1'b1);
      for (int n = 0; n < 4; n++) f2(12'h700 + 12'(16*n), 1'b1);
      chk("b2b_olock", 72'(olock2), 72'h1);
      chk("b2b_oerr_count", 72'(nerr2), 72'd0);
      idat2 = '0;
      isyn2 = 1'b1;
      step();
      chk("dut1_queue_drained", 72'(q1.size()), 72'd0);
      chk("dut2_queue_drained", 72'(q2.size()), 72'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
